// File: rtl/mitm_pkg.sv
// Shared types and helpers for the MITM serial buffers (read and write side).
package mitm_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      READING = 2'd1,
      COMMIT  = 2'd2
   } sr_state_t;

   // Width of a bit counter that must be able to hold the value `size`.
   function automatic int read_count_width(input int size);
      return $clog2(size + 1);
   endfunction

endpackage

// File: rtl/serial_read_buffer.sv
// Serial-to-parallel capture: samples data_in on each read_sig strobe, MSB first,
// and publishes the bits left-aligned on data_out once the requested count arrives.
module serial_read_buffer
   import mitm_pkg::*;
#(
   parameter int BUF_SIZE        = 8,
   parameter int READ_COUNT_SIZE = read_count_width(BUF_SIZE)
) (
   input  logic                       sys_clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       read_sig,
   input  logic                       data_in,
   input  logic [READ_COUNT_SIZE-1:0] read_count,
   output logic [BUF_SIZE-1:0]        data_out,
   output logic                       done_sig
);

   localparam int IDX_W = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;
   localparam logic [READ_COUNT_SIZE-1:0] MAX_N = READ_COUNT_SIZE'(BUF_SIZE);

   sr_state_t                  r_state;
   sr_state_t                  w_next_state;
   logic [READ_COUNT_SIZE-1:0] r_n;
   logic [READ_COUNT_SIZE-1:0] r_k;
   logic [READ_COUNT_SIZE-1:0] w_n_clamped;
   logic [READ_COUNT_SIZE-1:0] w_k_inc;
   logic [BUF_SIZE-1:0]        r_shift;
   logic [BUF_SIZE-1:0]        r_data_out;
   logic [BUF_SIZE-1:0]        w_keep_mask;
   logic [IDX_W-1:0]           w_pos;
   logic                       w_start_ok;
   logic                       w_strobe;
   logic                       w_last;

   // Oversized requests are clamped to the buffer capacity rather than rejected.
   assign w_n_clamped = (read_count > MAX_N) ? MAX_N : read_count;
   assign w_k_inc     = r_k + READ_COUNT_SIZE'(1);
   assign w_pos       = IDX_W'(BUF_SIZE - 1) - IDX_W'(r_k);
   assign w_start_ok  = start && (r_state == IDLE);
   assign w_strobe    = read_sig && (r_state == READING);
   assign w_last      = w_strobe && (w_k_inc == r_n);
   assign w_keep_mask = ~({BUF_SIZE{1'b1}} >> r_n);

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge sys_clk) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next_state;
   end

   // NOTE: every output of this block is given a default first, so no path infers a latch.
   always_comb begin
      w_next_state = r_state;
      done_sig     = 1'b1;
      unique case (r_state)
         IDLE: begin
            if (start) w_next_state = (w_n_clamped == '0) ? COMMIT : READING;
         end
         READING: begin
            done_sig = 1'b0;
            if (w_last) w_next_state = COMMIT;
         end
         COMMIT: begin
            // A zero-length capture never drops done_sig.
            done_sig     = (r_n == '0);
            w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // NOTE: the shift register is a handful of flops, not a RAM, so it is reset like any other state.
   always_ff @(posedge sys_clk) begin
      if (!rst) begin
         r_n        <= '0;
         r_k        <= '0;
         r_shift    <= '0;
         r_data_out <= '0;
      end else begin
         if (w_start_ok) begin
            r_n     <= w_n_clamped;
            r_k     <= '0;
            r_shift <= '0;
         end else if (w_strobe) begin
            r_shift[w_pos] <= data_in;
            r_k            <= w_k_inc;
         end
         if (r_state == COMMIT) r_data_out <= r_shift & w_keep_mask;
      end
   end

   assign data_out = r_data_out;

endmodule
